// File: rtl/alu_seq_if.sv
// Operation request / result bundle for alu_seq.
// in_valid/in_ready: an op transfers on a rising edge where both are 1; out_valid is a one-cycle pulse with no backpressure.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       aluCON;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             zero;
  logic             ov;
  logic             div_by_zero;

  modport master (
    output in_valid, aluCON, In1, In2,
    input  in_ready, out_valid, result, hi, lo, zero, ov, div_by_zero
  );

  modport slave (
    input  in_valid, aluCON, In1, In2,
    output in_ready, out_valid, result, hi, lo, zero, ov, div_by_zero
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, WIDTH-cycle shift-add multiply
// and restoring divide, with hi/lo result registers.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  alu_seq_if.slave    bus,
  output logic [1:0]  state_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHW-1:0]   LAST_CNT = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [3:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             accept, is_signed, a_neg, b_neg, last;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [SHW-1:0]   shamt;

  logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d, rem_q, rem_d, quo_q, quo_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               zero_q, zero_d, ov_q, ov_d, dbz_q, dbz_d;
  logic               neg_q, neg_d, rneg_q, rneg_d, pend_ov_q, pend_ov_d;

  logic [WIDTH-1:0]   sum, diff, alu_res;
  logic               alu_ov;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] mul_next, product;
  logic [WIDTH-1:0]   quo_next, rem_next, quo_fix, rem_fix;

  assign op        = bus.aluCON;
  assign a         = bus.In1;
  assign b         = bus.In2;
  assign shamt     = b[SHW-1:0];
  assign accept    = (state_q == S_IDLE) && bus.in_valid;
  assign is_signed = (op == 4'hB) || (op == 4'hD);
  assign a_neg     = is_signed && a[WIDTH-1];
  assign b_neg     = is_signed && b[WIDTH-1];
  assign mag_a     = a_neg ? -a : a;
  assign mag_b     = b_neg ? -b : b;
  assign last      = (cnt_q == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            4'hB, 4'hC: state_d = S_MUL;
            4'hD, 4'hE: state_d = (b == '0) ? S_DONE : S_DIV;
            default:    state_d = S_DONE;
          endcase
        end
      end
      S_MUL:   if (last) state_d = S_DONE;
      S_DIV:   if (last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Single-cycle ops; the reserved opcode falls through to a zero result.
  always_comb begin
    sum     = a + b;
    diff    = a - b;
    alu_res = '0;
    alu_ov  = 1'b0;
    case (op)
      4'h0: begin
        alu_res = sum;
        alu_ov  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'h1: begin
        alu_res = diff;
        alu_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'h2:    alu_res = a & b;
      4'h3:    alu_res = a | b;
      4'h4:    alu_res = a ^ b;
      4'h5:    alu_res = ~(a | b);
      4'h6:    alu_res = a << shamt;
      4'h7:    alu_res = a >> shamt;
      4'h8:    alu_res = $signed(a) >>> shamt;
      4'h9:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'hA:    alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  // One multiply / divide step on magnitudes; sign fix-up applied to the step's output.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
    product   = neg_q ? -mul_next : mul_next;
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, mcand_q};
    rem_next  = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
    quo_next  = {quo_q[WIDTH-2:0], ~div_trial[WIDTH]};
    quo_fix   = neg_q ? -quo_next : quo_next;
    rem_fix   = rneg_q ? -rem_next : rem_next;
  end

  always_comb begin
    result_d  = result_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    zero_d    = zero_q;
    ov_d      = ov_q;
    dbz_d     = dbz_q;
    mcand_d   = mcand_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    pend_ov_d = pend_ov_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d     = '0;
          neg_d     = a_neg ^ b_neg;
          rneg_d    = a_neg;
          pend_ov_d = (op == 4'hD) && (a == MIN_VAL) && (b == '1);
          case (op)
            4'hB, 4'hC: begin
              mcand_d = mag_a;
              prod_d  = {{WIDTH{1'b0}}, mag_b};
            end
            4'hD, 4'hE: begin
              if (b == '0) begin
                result_d = '1;
                lo_d     = '1;
                hi_d     = a;
                zero_d   = 1'b0;
                ov_d     = 1'b0;
                dbz_d    = 1'b1;
              end else begin
                mcand_d = mag_b;
                quo_d   = mag_a;
                rem_d   = '0;
              end
            end
            default: begin
              result_d = alu_res;
              zero_d   = (alu_res == '0);
              ov_d     = alu_ov;
              dbz_d    = 1'b0;
            end
          endcase
        end
      end
      S_MUL: begin
        cnt_d  = cnt_q + SHW'(1);
        prod_d = mul_next;
        if (last) begin
          hi_d     = product[2*WIDTH-1:WIDTH];
          lo_d     = product[WIDTH-1:0];
          result_d = product[WIDTH-1:0];
          zero_d   = (product[WIDTH-1:0] == '0);
          ov_d     = 1'b0;
          dbz_d    = 1'b0;
        end
      end
      S_DIV: begin
        cnt_d = cnt_q + SHW'(1);
        rem_d = rem_next;
        quo_d = quo_next;
        if (last) begin
          hi_d     = rem_fix;
          lo_d     = quo_fix;
          result_d = quo_fix;
          zero_d   = (quo_fix == '0);
          ov_d     = pend_ov_q;
          dbz_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      zero_q    <= 1'b0;
      ov_q      <= 1'b0;
      dbz_q     <= 1'b0;
      mcand_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      pend_ov_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      zero_q    <= zero_d;
      ov_q      <= ov_d;
      dbz_q     <= dbz_d;
      mcand_q   <= mcand_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      pend_ov_q <= pend_ov_d;
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.result      = result_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.zero        = zero_q;
  assign bus.ov          = ov_q;
  assign bus.div_by_zero = dbz_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: arithmetic reference model, per-cycle
// scoreboard compare, and literal checks on the headline cases.
module tb_alu_seq;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;

  alu_seq_if #(.WIDTH(W)) bus();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus), .state_o(state_dbg));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           due;
    int           lat;
    logic [W-1:0] res, hi, lo;
    logic         zero, ov, dbz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;
  int   start_cyc = 0;
  int   lat_seen = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [W-1:0] last_res = '0, last_hi = '0, last_lo = '0;
  logic         last_zero = 1'b0, last_ov = 1'b0, last_dbz = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic from the opcode definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb, full;
    longint unsigned ua, ub, pu;
    logic [4:0] sh;
    sa = $signed(a);  sb = $signed(b);
    ua = a;           ub = b;
    sh = b[4:0];
    e.due = 0; e.lat = 1; e.res = '0; e.hi = m_hi; e.lo = m_lo;
    e.ov = 1'b0; e.dbz = 1'b0; e.zero = 1'b0;
    case (op)
      4'h0: begin full = sa + sb; e.res = full[31:0]; e.ov = (full > SMAX) || (full < SMIN); end
      4'h1: begin full = sa - sb; e.res = full[31:0]; e.ov = (full > SMAX) || (full < SMIN); end
      4'h2: e.res = a & b;
      4'h3: e.res = a | b;
      4'h4: e.res = a ^ b;
      4'h5: e.res = ~(a | b);
      4'h6: e.res = a << sh;
      4'h7: e.res = a >> sh;
      4'h8: e.res = $signed(a) >>> sh;
      4'h9: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'hA: e.res = (ua < ub) ? 32'd1 : 32'd0;
      4'hB: begin full = sa * sb; e.hi = full[63:32]; e.lo = full[31:0]; e.res = e.lo; e.lat = W + 1; end
      4'hC: begin pu = ua * ub; e.hi = pu[63:32]; e.lo = pu[31:0]; e.res = e.lo; e.lat = W + 1; end
      4'hD, 4'hE: begin
        if (b == '0) begin
          e.res = '1; e.lo = '1; e.hi = a; e.dbz = 1'b1;
        end else if (op == 4'hD && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = a; e.hi = '0; e.res = a; e.ov = 1'b1; e.lat = W + 1;
        end else if (op == 4'hD) begin
          full = sa / sb; e.lo = full[31:0];
          full = sa % sb; e.hi = full[31:0];
          e.res = e.lo; e.lat = W + 1;
        end else begin
          pu = ua / ub; e.lo = pu[31:0];
          pu = ua % ub; e.hi = pu[31:0];
          e.res = e.lo; e.lat = W + 1;
        end
      end
      default: e.res = '0;
    endcase
    e.zero = (e.res == '0);
    m_hi = e.hi;
    m_lo = e.lo;
    return e;
  endfunction

  // Called at negedge+2 with in_ready already seen high; acceptance is the next posedge.
  task automatic drive_now(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = model(op, a, b);
    e.due = cyc + e.lat;
    exp_q.push_back(e);
    start_cyc = cyc;
    bus.in_valid = 1'b1;
    bus.aluCON = op;
    bus.In1 = a;
    bus.In2 = b;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk); #2;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    if (!bus.in_ready) begin
      checks++; failures++;
      $display("FAIL wait_ready timeout state=%0d", state_dbg);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    lat_seen = -1;
    while (n < 200) begin
      @(negedge clk); #2;
      if (bus.out_valid) begin
        lat_seen = cyc - start_cyc;
        return;
      end
      n++;
    end
    checks++; failures++;
    $display("FAIL wait_done timeout state=%0d", state_dbg);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    wait_ready();
    drive_now(op, a, b);
  endtask

  task automatic run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    do_op(op, a, b);
    wait_done();
  endtask

  // Every cycle: pulse exactly when due, in_ready only with nothing in flight, outputs hold otherwise.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (chk_en && !rst) begin
      if (exp_q.size() > 0 && cyc == exp_q[0].due) begin
        e = exp_q.pop_front();
        chk("out_valid_due", bus.out_valid, 1);
        chk("in_ready_done", bus.in_ready, 0);
        chk("result", bus.result, e.res);
        chk("hi", bus.hi, e.hi);
        chk("lo", bus.lo, e.lo);
        chk("zero", bus.zero, e.zero);
        chk("ov", bus.ov, e.ov);
        chk("div_by_zero", bus.div_by_zero, e.dbz);
        last_res = e.res; last_hi = e.hi; last_lo = e.lo;
        last_zero = e.zero; last_ov = e.ov; last_dbz = e.dbz;
      end else begin
        chk("out_valid_idle", bus.out_valid, 0);
        chk("in_ready", bus.in_ready, (exp_q.size() == 0) ? 1 : 0);
        chk("hold_result", bus.result, last_res);
        chk("hold_hi", bus.hi, last_hi);
        chk("hold_lo", bus.lo, last_lo);
        chk("hold_flags", {bus.zero, bus.ov, bus.div_by_zero}, {last_zero, last_ov, last_dbz});
      end
    end
  end

  localparam int NT = 20;
  logic [3:0]   t_op[NT] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h6, 4'h9, 4'h9, 4'hA,
                             4'h1, 4'h0, 4'hB, 4'hB, 4'hC, 4'hD, 4'hD, 4'hE, 4'hD, 4'hE};
  logic [W-1:0] t_a[NT]  = '{32'hF0F0F0F0, 32'h12340000, 32'hFFFF0000, 32'h0, 32'h1,
                             32'h80000000, 32'h0000ABCD, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF,
                             32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFD, 32'hFFFFFFFF,
                             32'h7, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h5, 32'h3};
  logic [W-1:0] t_b[NT]  = '{32'hFF00FF00, 32'h00005678, 32'h0F0F0F0F, 32'h0, 32'h3F,
                             32'h4, 32'h0, 32'h1, 32'hFFFFFFFF, 32'h1,
                             32'h1, 32'h1, 32'h80000000, 32'h5, 32'hFFFFFFFF,
                             32'hFFFFFFFE, 32'h3, 32'hA, 32'h0, 32'h9};

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.aluCON = '0;
    bus.In1 = '0;
    bus.In2 = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_flags", {bus.zero, bus.ov, bus.div_by_zero}, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    run(4'h0, 32'h7FFFFFFF, 32'h1);
    chk("add_ovf_lat", lat_seen, 1);
    chk("add_ovf_res", bus.result, 32'h80000000);
    chk("add_ovf_ov", bus.ov, 1);
    chk("add_ovf_zero", bus.zero, 0);

    run(4'h1, 32'h5, 32'h5);
    chk("sub_res", bus.result, 0);
    chk("sub_zero", bus.zero, 1);
    chk("sub_ov", bus.ov, 0);

    run(4'h8, 32'h80000000, 32'h21);
    chk("sra_res", bus.result, 32'hC0000000);

    run(4'hA, 32'h1, 32'hFFFFFFFF);
    chk("sltu_res", bus.result, 32'h1);

    do_op(4'hB, 32'hFFFFFFFF, 32'h2);
    repeat (5) begin
      @(negedge clk); #2;
      bus.in_valid = 1'b1; bus.aluCON = 4'h0; bus.In1 = 32'h1; bus.In2 = 32'h1;
    end
    bus.in_valid = 1'b0;
    wait_done();
    chk("mult_lat", lat_seen, 33);
    chk("mult_hi", bus.hi, 32'hFFFFFFFF);
    chk("mult_lo", bus.lo, 32'hFFFFFFFE);

    run(4'hD, 32'hFFFFFFF9, 32'h2);
    chk("div_neg_lo", bus.lo, 32'hFFFFFFFD);
    chk("div_neg_hi", bus.hi, 32'hFFFFFFFF);

    run(4'hE, 32'h7, 32'h0);
    chk("divu_z_lat", lat_seen, 1);
    chk("divu_z_lo", bus.lo, 32'hFFFFFFFF);
    chk("divu_z_hi", bus.hi, 32'h7);
    chk("divu_z_dbz", bus.div_by_zero, 1);

    run(4'hD, 32'h80000000, 32'hFFFFFFFF);
    chk("div_min_lo", bus.lo, 32'h80000000);
    chk("div_min_hi", bus.hi, 32'h0);
    chk("div_min_ov", bus.ov, 1);

    run(4'hF, 32'h1234, 32'h5678);
    chk("rsvd_res", bus.result, 0);
    chk("rsvd_zero", bus.zero, 1);
    chk("rsvd_lo_held", bus.lo, 32'h80000000);

    for (int i = 0; i < NT; i++) run(t_op[i], t_a[i], t_b[i]);

    do_op(4'hE, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    m_hi = '0; m_lo = '0;
    last_res = '0; last_hi = '0; last_lo = '0;
    last_zero = 1'b0; last_ov = 1'b0; last_dbz = 1'b0;
    #1;
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_hi", bus.hi, 0);
    chk("midrst_lo", bus.lo, 0);
    chk("midrst_result", bus.result, 0);
    @(negedge clk); #2;
    rst = 1'b0;
    drive_now(4'h0, 32'h2, 32'h3);
    wait_done();
    chk("post_rst_lat", lat_seen, 1);
    chk("post_rst_res", bus.result, 32'h5);

    repeat (3) @(negedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath width; power of two, 8..64.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operation request.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operation this cycle.
REQ-006 SHALL have port: aluCON  input  4  opcode.
REQ-007 SHALL have ports: In1, In2  input  WIDTH  operands.
REQ-008 SHALL have port: out_valid  output  1  one-cycle pulse; result, zero, ov and div_by_zero valid.
REQ-009 SHALL have port: result  output  WIDTH  operation result.
REQ-010 SHALL have ports: hi, lo  output  WIDTH  multiply/divide result registers.
REQ-011 SHALL have ports: zero, ov, div_by_zero  output  1 each  status flags.

Function
REQ-012 Opcodes SHALL be: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 sll, 7 srl, 8 sra, 9 slt (signed), A sltu, B mult (signed), C multu, D div (signed), E divu, F reserved.
REQ-013 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; operands and opcode SHALL be captured then and ignored thereafter.
REQ-014 FSM SHALL have states IDLE, MUL, DIV, DONE; in_ready=1 only in IDLE.
REQ-015 Ops 0-A and F SHALL go IDLE->DONE; out_valid SHALL pulse the cycle after acceptance (latency 1).
REQ-016 Mult/multu SHALL go IDLE->MUL and run WIDTH shift-add iterations, one per cycle, then DONE; out_valid SHALL assert exactly WIDTH+1 cycles after acceptance.
REQ-017 Div/divu SHALL go IDLE->DIV and run WIDTH restoring iterations, one per cycle, then DONE; out_valid SHALL assert exactly WIDTH+1 cycles after acceptance.
REQ-018 DONE SHALL last one cycle, assert out_valid, then return to IDLE; there is no output backpressure.
REQ-019 Shift amount SHALL be In2[log2(WIDTH)-1:0]; upper bits SHALL be ignored.
REQ-020 Slt/sltu SHALL produce result 1 or 0, zero-extended to WIDTH.
REQ-021 Multiply SHALL produce a 2*WIDTH product, with {hi,lo} = product and result = lo; the signed form SHALL use magnitude multiply plus sign fix-up.
REQ-022 Divide SHALL set lo = quotient, hi = remainder and result = lo; the signed quotient SHALL truncate toward zero and the remainder SHALL take the dividend's sign.
REQ-023 Divisor 0 SHALL skip iteration (latency 1) and produce lo = all ones, hi = In1, result = all ones, div_by_zero=1.
REQ-024 Signed div of MIN by -1 SHALL produce lo = MIN, hi = 0, ov=1.
REQ-025 Ov SHALL be two's-complement signed overflow for add/sub, 1 per REQ-024, and 0 otherwise.
REQ-026 Zero SHALL equal (result == 0) for every op.
REQ-027 Hi/lo SHALL update only on mul/div completion and hold their values across all other ops.
REQ-028 Reserved opcode F SHALL produce result 0, zero=1, ov=0, hi/lo unchanged.
REQ-029 Result and flags SHALL hold their last values between out_valid pulses.
REQ-030 in_valid while in_ready=0 SHALL be ignored and SHALL not be queued.

Reset
REQ-031 Asserting rst at any time, including mid-MUL/DIV, SHALL immediately force IDLE and set in_ready=1, out_valid=0, result=0, hi=0, lo=0, zero=0, ov=0, div_by_zero=0; the in-flight op SHALL be discarded.
REQ-032 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Verification (WIDTH=32)
REQ-033 add 0x7FFFFFFF+1 -> out_valid next cycle, result 0x80000000, ov=1, zero=0; sub 5-5 -> result 0, zero=1, ov=0.
REQ-034 sra 0x80000000 by In2=0x21 -> result 0xC0000000 (shift 1); sltu 1,0xFFFFFFFF -> result 1.
REQ-035 mult 0xFFFFFFFF*2 -> out_valid exactly 33 cycles after acceptance, hi=0xFFFFFFFF, lo=0xFFFFFFFE; in_ready=0 throughout.
REQ-036 div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/0 -> 1-cycle latency, lo=0xFFFFFFFF, hi=7, div_by_zero=1.
REQ-037 rst pulse 10 cycles into divu -> in_ready=1 and hi=lo=0 immediately, no out_valid; next add 2+3 -> result 5 after 1 cycle.
